// File: rtl/move_sequencer.sv
// Purpose : turns face/turn move commands into a start pulse, direction and step count for one
//           of six stepper drivers, waits for that driver's done, then enforces a dwell gap.
// Latency : accept -> start pulse 1 cycle; driver done seen -> move_ready GAP_CYCLES cycles.
// Backpressure: move_ready is high only in IDLE; the source holds move_valid/face/turn until taken.
// Ports   : clock, reset_n (async active-low); move_valid/move_face/move_turn/move_ready command
//           handshake; start_out/dir_out/steps_out driver command; done_in driver completion;
//           busy, move_count, bad_cmd status; timeout sticky watchdog flag (MOVE_TIMEOUT_EN only).
// Options : define MOVE_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYCLES cycles.
module move_sequencer #(
    parameter int          STEPS_PER_QUARTER = 50,
    parameter int          GAP_CYCLES        = 1000,
    parameter logic [23:0] TIMEOUT_CYCLES    = 24'd10_000_000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        move_valid,
    input  logic [2:0]  move_face,
    input  logic [1:0]  move_turn,
    output logic        move_ready,
    output logic [5:0]  start_out,
    output logic        dir_out,
    output logic [7:0]  steps_out,
    input  logic [5:0]  done_in,
    output logic        busy,
    output logic [15:0] move_count,
    output logic        bad_cmd
`ifdef MOVE_TIMEOUT_EN
    ,
    output logic        timeout
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SETTLE,
        S_WAIT,
        S_GAP
    } state_t;

    // Gap counter only has to hold GAP_CYCLES-1.
    localparam int             GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]  GAP_LOAD = GW'(GAP_CYCLES - 1);
    localparam logic [7:0]     STEPS_Q  = 8'(STEPS_PER_QUARTER);

    state_t         r_state;
    state_t         w_next;
    logic [2:0]     r_face;
    logic           r_dir;
    logic [7:0]     r_steps;
    logic [15:0]    r_count;
    logic           r_bad_cmd;
    logic [GW-1:0]  r_gap;

    logic           w_accept;
    logic           w_face_bad;
    logic           w_done_sel;
    logic           w_ready_ok;
    logic           w_wd_expire;

`ifdef MOVE_TIMEOUT_EN
    logic [23:0]    r_wd_cnt;
    logic           r_timeout;

    assign w_wd_expire = (r_wd_cnt == (TIMEOUT_CYCLES - 24'd1));
    assign w_ready_ok  = ~r_timeout;
    assign timeout     = r_timeout;
`else
    logic           w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_wd_expire      = 1'b0;
    assign w_ready_ok       = 1'b1;
`endif

    // reset_n gates ready so the sequencer never advertises readiness while held in reset.
    assign move_ready = (r_state == S_IDLE) & reset_n & w_ready_ok;
    assign w_accept   = move_valid & move_ready;
    assign w_face_bad = (move_face > 3'd5);
    assign w_done_sel = done_in[r_face];

    assign start_out  = (r_state == S_START) ? (6'b000001 << r_face) : 6'b000000;
    assign dir_out    = r_dir;
    assign steps_out  = r_steps;
    assign busy       = (r_state != S_IDLE);
    assign move_count = r_count;
    assign bad_cmd    = r_bad_cmd;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_face_bad) begin
                    w_next = (move_turn == 2'd0) ? S_GAP : S_START;
                end
            end
            S_START:  w_next = S_SETTLE;
            // Driver's done from the previous move may still be high here.
            S_SETTLE: w_next = S_WAIT;
            S_WAIT: begin
                if (w_done_sel) begin
                    w_next = S_GAP;
                end else if (w_wd_expire) begin
                    w_next = S_IDLE;
                end
            end
            S_GAP: begin
                if (r_gap == '0) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_face    <= 3'd0;
            r_dir     <= 1'b0;
            r_steps   <= 8'd0;
            r_count   <= 16'd0;
            r_bad_cmd <= 1'b0;
            r_gap     <= '0;
        end else begin
            r_bad_cmd <= w_accept & w_face_bad;

            // Driver command fields only move for a real turn; they hold otherwise.
            if (w_accept && !w_face_bad && (move_turn != 2'd0)) begin
                r_face  <= move_face;
                r_dir   <= (move_turn != 2'd3);
                r_steps <= (move_turn == 2'd2) ? {STEPS_Q[6:0], 1'b0} : STEPS_Q;
            end

            if ((w_accept && !w_face_bad && (move_turn == 2'd0)) ||
                ((r_state == S_WAIT) && w_done_sel)) begin
                r_count <= r_count + 16'd1;
            end

            if ((w_next == S_GAP) && (r_state != S_GAP)) begin
                r_gap <= GAP_LOAD;
            end else if ((r_state == S_GAP) && (r_gap != '0)) begin
                r_gap <= r_gap - 1'b1;
            end
        end
    end

`ifdef MOVE_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wd_cnt  <= 24'd0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == S_SETTLE) begin
                r_wd_cnt <= 24'd0;
            end else if (r_state == S_WAIT) begin
                r_wd_cnt <= r_wd_cnt + 24'd1;
            end
            if ((r_state == S_WAIT) && !w_done_sel && w_wd_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_move_sequencer.sv
module tb_move_sequencer;

    localparam int G   = 10;
    localparam int SPQ = 50;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        move_valid;
    logic [2:0]  move_face;
    logic [1:0]  move_turn;
    logic        move_ready;
    logic [5:0]  start_out;
    logic        dir_out;
    logic [7:0]  steps_out;
    logic [5:0]  done_in;
    logic        busy;
    logic [15:0] move_count;
    logic        bad_cmd;
`ifdef MOVE_TIMEOUT_EN
    logic        timeout;
`endif

    always #5 clock = ~clock;

    move_sequencer #(
        .STEPS_PER_QUARTER(SPQ),
        .GAP_CYCLES(G)
`ifdef MOVE_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(24'd100)
`endif
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .move_valid(move_valid),
        .move_face(move_face),
        .move_turn(move_turn),
        .move_ready(move_ready),
        .start_out(start_out),
        .dir_out(dir_out),
        .steps_out(steps_out),
        .done_in(done_in),
        .busy(busy),
        .move_count(move_count),
        .bad_cmd(bad_cmd)
`ifdef MOVE_TIMEOUT_EN
        ,
        .timeout(timeout)
`endif
    );

    // Driver model: drops done on the first falling edge of the start cycle,
    // then raises it again after steps_out more cycles.
    logic       auto_drv;
    logic [5:0] done_man;
    logic [5:0] done_mod = 6'h3F;
    int         mcnt [6] = '{default: 0};

    assign done_in = auto_drv ? done_mod : done_man;

    always @(negedge clock) begin
        for (int f = 0; f < 6; f++) begin
            if (start_out[f]) begin
                done_mod[f] <= 1'b0;
                mcnt[f]     <= int'(steps_out);
            end else if (mcnt[f] > 0) begin
                mcnt[f] <= mcnt[f] - 1;
                if (mcnt[f] == 1) done_mod[f] <= 1'b1;
            end
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!move_ready && n < 1000) begin
            tick();
            n++;
        end
        chk({nm, "_ready"}, 32'(move_ready), 32'd1);
    endtask

    task automatic issue(input logic [2:0] f, input logic [1:0] t);
        move_valid = 1'b1;
        move_face  = f;
        move_turn  = t;
        tick();
        move_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0] face;
        logic [1:0] turn;
        logic [5:0] st;
        logic       dir;
        logic [7:0] steps;
        logic       bad;
        int         inc;
    } vec_t;

    vec_t tbl [8];

    typedef struct {
        logic [2:0] face;
        logic [1:0] turn;
        logic [5:0] st;
    } b2b_t;

    b2b_t q [3];

    initial begin
        int acc;
        int rc;
        int idx;
        int n;
        int lim;
        logic acc_now;

        tbl[0] = '{3'd2, 2'd1, 6'b000100, 1'b1, 8'd50,  1'b0, 1};
        tbl[1] = '{3'd5, 2'd3, 6'b100000, 1'b0, 8'd50,  1'b0, 1};
        tbl[2] = '{3'd0, 2'd2, 6'b000001, 1'b1, 8'd100, 1'b0, 1};
        tbl[3] = '{3'd6, 2'd1, 6'b000000, 1'b1, 8'd100, 1'b1, 0};
        tbl[4] = '{3'd7, 2'd3, 6'b000000, 1'b1, 8'd100, 1'b1, 0};
        tbl[5] = '{3'd3, 2'd0, 6'b000000, 1'b1, 8'd100, 1'b0, 1};
        tbl[6] = '{3'd4, 2'd1, 6'b010000, 1'b1, 8'd50,  1'b0, 1};
        tbl[7] = '{3'd1, 2'd3, 6'b000010, 1'b0, 8'd50,  1'b0, 1};
        q[0]   = '{3'd3, 2'd1, 6'b001000};
        q[1]   = '{3'd4, 2'd3, 6'b010000};
        q[2]   = '{3'd0, 2'd1, 6'b000001};

        // Reset state
        reset_n    = 1'b0;
        move_valid = 1'b0;
        move_face  = 3'd0;
        move_turn  = 2'd0;
        auto_drv   = 1'b1;
        done_man   = 6'h3F;
        #1;
        chk("rst_ready", 32'(move_ready), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_start", 32'(start_out), 0);
        chk("rst_count", 32'(move_count), 0);
        chk("rst_bad",   32'(bad_cmd), 0);
        chk("rst_dir",   32'(dir_out), 0);
        chk("rst_steps", 32'(steps_out), 0);
        repeat (3) @(posedge clock);
        #3 reset_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(move_ready), 1);

        // Table of single commands
        for (int i = 0; i < 8; i++) begin
            wait_ready("tbl_pre");
            issue(tbl[i].face, tbl[i].turn);
            acc = cyc;
            chk("tbl_start", 32'(start_out), 32'(tbl[i].st));
            chk("tbl_dir",   32'(dir_out),   32'(tbl[i].dir));
            chk("tbl_steps", 32'(steps_out), 32'(tbl[i].steps));
            chk("tbl_bad",   32'(bad_cmd),   32'(tbl[i].bad));
            chk("tbl_busy",  32'(busy),      32'(!tbl[i].bad));
            tick();
            chk("tbl_start_1cyc", 32'(start_out), 0);
            chk("tbl_bad_1cyc",   32'(bad_cmd), 0);
            wait_ready("tbl_done");
            exp_count += tbl[i].inc;
            chk("tbl_count", 32'(move_count), 32'(exp_count));
            if (tbl[i].turn == 2'd0 && !tbl[i].bad)
                chk("noop_gap", 32'(cyc - acc), 32'(G));
        end

        // Stale done through START/SETTLE, other faces done, then real done
        auto_drv = 1'b0;
        done_man = 6'h3F;
        wait_ready("stale_pre");
        issue(3'd1, 2'd1);
        chk("stale_start", 32'(start_out), 32'h02);
        tick();
        tick();
        done_man = 6'b111101;
        repeat (5) tick();
        chk("stale_busy",  32'(busy), 1);
        chk("stale_ready", 32'(move_ready), 0);
        chk("stale_count", 32'(move_count), 32'(exp_count));
        done_man[1] = 1'b1;
        rc = cyc;
        wait_ready("stale_done");
        chk("done_to_ready", 32'(cyc - rc), 32'(G + 1));
        exp_count++;
        chk("stale_count2", 32'(move_count), 32'(exp_count));

        // Back-to-back: valid held, three queued moves
        auto_drv = 1'b1;
        repeat (60) tick();
        idx = 0;
        n   = 0;
        lim = 0;
        move_valid = 1'b1;
        move_face  = q[0].face;
        move_turn  = q[0].turn;
        while ((idx < 3 || busy) && lim < 3000) begin
            acc_now = move_ready && move_valid;
            tick();
            lim++;
            if (start_out != 6'd0) begin
                chk("b2b_start", 32'(start_out), (n < 3) ? 32'(q[n].st) : 32'd0);
                chk("b2b_drivers_idle", 32'(done_in), 32'h3F);
                n++;
            end
            if (acc_now) begin
                idx++;
                if (idx < 3) begin
                    move_face = q[idx].face;
                    move_turn = q[idx].turn;
                end else begin
                    move_valid = 1'b0;
                end
            end
        end
        move_valid = 1'b0;
        chk("b2b_pulses", 32'(n), 32'd3);
        exp_count += 3;
        chk("b2b_count", 32'(move_count), 32'(exp_count));

`ifdef MOVE_TIMEOUT_EN
        // Watchdog: done never returns
        auto_drv = 1'b0;
        done_man = 6'h00;
        wait_ready("to_pre");
        issue(3'd2, 2'd1);
        acc = cyc;
        lim = 0;
        while (!timeout && lim < 300) begin
            tick();
            lim++;
        end
        chk("to_flag",    32'(timeout), 1);
        chk("to_latency", 32'(cyc - acc), 32'd102);
        chk("to_busy",    32'(busy), 0);
        chk("to_count",   32'(move_count), 32'(exp_count));
        repeat (5) tick();
        chk("to_ready_held", 32'(move_ready), 0);
        chk("to_sticky",     32'(timeout), 1);
        #3 reset_n = 1'b0;
        #1;
        chk("to_rst_clear", 32'(timeout), 0);
        #8 reset_n = 1'b1;
        tick();
        chk("to_rst_ready", 32'(move_ready), 1);
        exp_count = 0;
        auto_drv = 1'b1;
        done_man = 6'h3F;
        repeat (60) tick();
`endif

        // Asynchronous reset in WAIT
        wait_ready("arst_pre");
        issue(3'd5, 2'd2);
        repeat (10) tick();
        chk("arst_busy_before", 32'(busy), 1);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_busy",  32'(busy), 0);
        chk("arst_start", 32'(start_out), 0);
        chk("arst_ready", 32'(move_ready), 0);
        chk("arst_count", 32'(move_count), 0);
        chk("arst_dir",   32'(dir_out), 0);
        chk("arst_steps", 32'(steps_out), 0);
        #8 reset_n = 1'b1;
        #1;
        chk("arst_release_ready", 32'(move_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
